// File: rtl/nested_struct_decoder.sv
// Receive-side decoder: restores nested_struct_t fields and buffers results in a small FIFO.
// Define NESTED_DEC_CHECK_EN to compile in the consistency checker (out_err, err_count).
package main_pkg;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        valid;
  } base_t;

  typedef struct packed {
    base_t       base;
    logic [15:0] id;
    logic [3:0]  cmd;
    logic        ready;
  } nested_struct_t;
endpackage

module nested_struct_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  main_pkg::nested_struct_t   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output main_pkg::nested_struct_t   out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  main_pkg::nested_struct_t dec;
  main_pkg::nested_struct_t ram [DEPTH];
  main_pkg::nested_struct_t head_q, head_d;
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop, head_from_in;

  always_comb begin
    dec            = in_data;
    dec.base.addr  = in_data.base.addr - 8'd1;
    dec.base.data  = in_data.base.data ^ 32'hDEAD_BEEF;
    dec.id         = in_data.id - 16'd100;
    dec.cmd        = in_data.cmd & 4'b0101;
    dec.base.valid = in_data.ready;
    dec.ready      = in_data.base.valid;
  end

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head register is refilled from the slot rd_d points at; when that slot
  // is being written this very cycle the RAM is stale, so take the decoded word.
  always_comb begin
    rd_d         = pop ? rd_q + AW'(1) : rd_q;
    level_d      = level_q + LW'(push) - LW'(pop);
    head_from_in = push && (rd_d == wr_q);
    head_d       = head_q;
    if (level_d != '0) head_d = head_from_in ? dec : ram[rd_d];
  end

  always_ff @(posedge clk) begin
    if (push) ram[wr_q] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      rd_q    <= rd_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  assign out_data = head_q;
  assign level    = level_q;

`ifdef NESTED_DEC_CHECK_EN
  logic             dec_err;
  logic             err_ram [DEPTH];
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  assign dec_err = ~in_data.cmd[3] | ~in_data.cmd[1] | (in_data.base.valid & ~in_data.ready);

  always_comb begin
    err_d = err_q;
    if (level_d != '0) err_d = head_from_in ? dec_err : err_ram[rd_d];
  end

  always_ff @(posedge clk) begin
    if (push) err_ram[wr_q] <= dec_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (push && dec_err && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_err   = err_q;
  assign err_count = cnt_q;
`else
  assign out_err   = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_nested_struct_decoder.sv
// Directed self-checking bench for nested_struct_decoder.
module tb_nested_struct_decoder;
  import main_pkg::*;

`ifdef NESTED_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  nested_struct_t in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  nested_struct_t out_data;
  logic           out_err;
  logic [2:0]     level;
  logic [7:0]     err_count;

  int n_checks = 0;
  int n_errors = 0;

  nested_struct_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .level(level), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic nested_struct_t mk(input logic [7:0] addr, input logic [31:0] data,
                                        input logic valid, input logic [15:0] id,
                                        input logic [3:0] cmd, input logic ready);
    nested_struct_t s;
    s.base.addr = addr; s.base.data = data; s.base.valid = valid;
    s.id = id; s.cmd = cmd; s.ready = ready;
    return s;
  endfunction

  // Stream word i: addr 0x40+i, data 0x10000000+i, id 0x0070+i, cmd 0xA, valid/ready 1.
  function automatic nested_struct_t stream_in(input int i);
    return mk(8'h40 + 8'(i), 32'h1000_0000 + 32'(i), 1'b1, 16'h0070 + 16'(i), 4'hA, 1'b1);
  endfunction

  // Restored: addr 0x3F+i, data 0xCEADBEEF^i, id 0x000C+i, cmd 0.
  function automatic nested_struct_t stream_exp(input int i);
    return mk(8'h3F + 8'(i), 32'hCEAD_BEEF ^ 32'(i), 1'b1, 16'h000C + 16'(i), 4'h0, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    step();

    // Round trip
    in_data = mk(8'h10, 32'h1234_5678, 1'b1, 16'h0164, 4'hE, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rt_valid", 64'(out_valid), 64'd1);
    check("rt_data", 64'(out_data), 64'(mk(8'h0F, 32'hCC99_E897, 1'b1, 16'h0100, 4'h4, 1'b1)));
    check("rt_err", 64'(out_err), 64'd0);
    check("rt_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("rt_empty", 64'(out_valid), 64'd0);

    // Wrap arithmetic
    in_data = mk(8'h00, 32'h0000_0000, 1'b1, 16'h0000, 4'hA, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("wrap_data", 64'(out_data), 64'(mk(8'hFF, 32'hDEAD_BEEF, 1'b1, 16'hFF9C, 4'h0, 1'b1)));
    check("wrap_err", 64'(out_err), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Error words
    in_valid = 1'b1;
    in_data = mk(8'h20, 32'h0000_0000, 1'b0, 16'h0064, 4'h4, 1'b0);
    step();
    in_data = mk(8'h30, 32'hDEAD_BEEF, 1'b1, 16'h0069, 4'hF, 1'b0);
    step();
    in_valid = 1'b0;
    check("err_level", 64'(level), 64'd2);
    check("err_head0", 64'(out_data), 64'(mk(8'h1F, 32'hDEAD_BEEF, 1'b0, 16'h0000, 4'h4, 1'b0)));
    check("err_flag0", 64'(out_err), 64'(CHK));
    check("err_count", 64'(err_count), CHK ? 64'd2 : 64'd0);
    out_ready = 1'b1;
    step();
    check("err_head1", 64'(out_data), 64'(mk(8'h2F, 32'h0000_0000, 1'b0, 16'h0005, 4'h5, 1'b1)));
    check("err_flag1", 64'(out_err), 64'(CHK));
    step();
    out_ready = 1'b0;
    check("err_drained", 64'(level), 64'd0);

    // Backpressure: five words offered into four slots
    for (int i = 0; i < 5; i++) begin
      in_data = stream_in(i);
      in_valid = 1'b1;
      check("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    check("bp_level", 64'(level), 64'd4);
    check("bp_full", 64'(in_ready), 64'd0);
    step();
    check("bp_held", 64'(level), 64'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_data", 64'(out_data), 64'(stream_exp(i)));
      step();
    end
    out_ready = 1'b0;
    check("bp_empty", 64'(level), 64'd0);

    // Concurrent push/pop at level 2
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = stream_in(i);
      step();
    end
    check("cc_level_init", 64'(level), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = stream_in(c + 2);
      check("cc_head", 64'(out_data), 64'(stream_exp(c)));
      step();
      check("cc_level", 64'(level), 64'd2);
    end
    in_valid = 1'b0;
    for (int c = 10; c < 12; c++) begin
      check("cc_tail", 64'(out_data), 64'(stream_exp(c)));
      step();
    end
    out_ready = 1'b0;
    check("cc_empty", 64'(level), 64'd0);

    // Reset mid-stream at level 3
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(8'h55, 32'h0, 1'b0, 16'h0, 4'h0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    check("mr_level_pre", 64'(level), 64'd3);
    check("mr_cnt_pre", 64'(err_count), CHK ? 64'd5 : 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_level", 64'(level), 64'd0);
    check("mr_err_count", 64'(err_count), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_out_data", 64'(out_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_after_level", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nested_struct_decoder.md
# nested_struct_decoder

Receive-side counterpart of the nested-struct processing stage. Accepts processed `main_pkg::nested_struct_t` words over a valid/ready stream, reverses the field transform and buffers results in a small FIFO. Flags words that the processing stage could never have produced. Sits between the processing stage's output register and downstream consumers that need the original field values.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 8: width of the error counter.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: decoder can accept; equals not-full.
- `in_data` input 62: processed `main_pkg::nested_struct_t`.
- `out_valid` output 1: FIFO head valid; equals not-empty.
- `out_ready` input 1: consumer accepts the head.
- `out_data` output 62: restored `main_pkg::nested_struct_t`.
- `out_err` output 1: head word failed the consistency check.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.
- `err_count` output CNT_W: saturating count of erroneous words accepted.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`. Decode is combinational at push; the FIFO stores the decoded word plus its error bit.
- Field restore rules:
  - `base.addr` = in `base.addr` − 1, mod 256 (0x00 → 0xFF).
  - `base.data` = in `base.data` ^ 0xDEADBEEF.
  - `id` = in `id` − 100, mod 65536 (0x0000 → 0xFF9C).
  - `cmd` = in `cmd` & 4'b0101. Bits 3 and 1 are unrecoverable and are cleared.
  - `base.valid` = in `ready`.
  - `ready` = in `base.valid`.
- Error rule: `err` = (in `cmd[3]` == 0) | (in `cmd[1]` == 0) | (in `base.valid` & ~in `ready`).
- `err_count` increments on every push with `err` = 1 and saturates at 2^CNT_W−1.
- Full: `in_ready` = 0. There is no bypass; a simultaneous pop while full does not admit a push that cycle.
- Empty: `out_valid` = 0. `out_data` and `out_err` hold the last popped entry's RAM contents and are don't-care.
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged and order is preserved.
- Read and write pointers wrap modulo DEPTH. Full/empty are derived from `level`.

## Timing
- Reset (`rst_n` low, asynchronous) clears pointers, `level`, `err_count` and the registered output. The FIFO RAM is not reset.
- Output values during and after reset: `out_valid` = 0, `out_data` = 0, `out_err` = 0, `level` = 0, `err_count` = 0, `in_ready` = 1.
- Reset asserted mid-stream discards all buffered words. No partial pop is visible.
- Latency: a word pushed at edge N is presented with `out_valid` = 1 after edge N (cycle N+1) if the FIFO was empty.
- Throughput: one word per cycle sustained when `out_ready` = 1.
- `out_data`/`out_err` are stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` depends only on state, never combinationally on `out_ready`.

## Configuration
- `NESTED_DEC_CHECK_EN` defined: the error rule, `out_err` storage and `err_count` are compiled in as above.
- `NESTED_DEC_CHECK_EN` undefined: no checker logic. `out_err` is tied to 0 and `err_count` is tied to 0. Field restore and FIFO behaviour are unchanged.

## Test plan
- Round trip: push addr 0x10, data 0x12345678, valid 1, id 0x0164, cmd 0xE, ready 1. Expect next cycle out addr 0x0F, data 0xCC99E897, base.valid 1, id 0x0100, cmd 0x4, ready 1, `out_err` 0.
- Wrap arithmetic: push addr 0x00, id 0x0000, cmd 0xA. Expect addr 0xFF, id 0xFF9C, cmd 0x0, `out_err` 0.
- Errors: push cmd 0x4, then base.valid 1 with ready 0. Expect `out_err` 1 on both heads and `err_count` 2. Without the macro, expect `out_err` 0 and `err_count` 0.
- Backpressure: hold `out_ready` 0 and push 5 words with DEPTH 4. Expect `in_ready` 0 after 4 words, `level` 4, the 5th word held off, then in-order drain once `out_ready` is 1.
- Concurrent push/pop at level 2 for 10 cycles. Expect `level` to stay at 2 and no loss or reordering.
- Reset mid-stream at level 3: expect `out_valid` 0, `level` 0, `err_count` 0 and `in_ready` 1 immediately and asynchronously.
